fetch_hazard_ctrl: RTL and testbench
====================================

Name: fetch_hazard_ctrl

Overview:
Pipeline sequencing controller for the IF stage of the MIPS R2000 core. It arbitrates competing redirect and stall requests: exceptions, taken branches, multiply/divide busy, load-use hazards and instruction-memory wait. From these it drives the IF stage's hold_pc, hold_if, br, except and pc_branch inputs, plus a bubble-insert (flush) to the ID/EX boundary. It owns the mult/div busy counter, the exception-flush sequencer and a stall performance counter.

Parameters:
MULT_CYCLES, 5, cycles HI/LO stay busy after a MULT/MULTU start.
DIV_CYCLES, 33, cycles HI/LO stay busy after a DIV/DIVU start.
EXC_FLUSH_CYCLES, 2, cycles of forced ID bubbles after an exception redirect.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
id_rs  in  5  rs field of the instruction in ID.
id_rt  in  5  rt field of the instruction in ID.
id_uses_rt  in  1  ID instruction reads rt as a source.
id_reads_hilo  in  1  ID instruction is MFHI/MFLO.
ex_memread  in  1  EX instruction is a load.
ex_rt  in  5  destination register of the EX load.
ex_br_taken  in  1  branch/jump resolved taken in EX.
ex_br_target  in  32  resolved branch target.
exc_req  in  1  exception raised this cycle.
exc_pc  in  32  PC of the faulting instruction.
md_start  in  1  mult/div issued from EX this cycle.
md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply.
imem_ready  in  1  instruction memory returns a valid word this cycle.
hold_pc  out  1  freeze the PC register.
hold_if  out  1  freeze the IF/ID instruction register.
flush_id  out  1  insert a NOP into ID/EX.
br  out  1  select pc_branch as next PC.
except  out  1  select the exception vector 0x8000_0180 as next PC.
pc_branch  out  32  redirect target (copy of ex_br_target).
epc  out  32  latched PC of the last taken exception.
md_busy  out  1  HI/LO result pending.
stall_cycles  out  32  count of cycles with hold_pc=1.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, md counter=0, epc=0, stall_cycles=0. All control outputs are 0 while in reset.
- Control outputs (hold_pc, hold_if, flush_id, br, except, pc_branch) are combinational from the current state, the counter and the inputs. epc, the md counter, state and stall_cycles are registered.
- Priority, first match wins:
  1. Exception: state=RUN and exc_req=1 -> except=1, br=0, flush_id=1, hold_pc=0, hold_if=0. At the next edge, epc<=exc_pc, state<=EXC_FLUSH, flush counter<=EXC_FLUSH_CYCLES-1.
  2. Branch: ex_br_taken=1 -> br=1, pc_branch=ex_br_target, flush_id=1, hold_pc=0, hold_if=0. This overrides any stall source below.
  3. HI/LO hazard: md_busy=1 and id_reads_hilo=1 -> hold_pc=1, hold_if=1, flush_id=1.
  4. Load-use: ex_memread=1, ex_rt!=0, and (ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt)) -> hold_pc=1, hold_if=1, flush_id=1, for exactly one cycle per occurrence.
  5. Imem wait: imem_ready=0 -> hold_pc=1, hold_if=1, flush_id=1.
  6. Otherwise all control outputs are 0.
- EXC_FLUSH state:
  - flush_id=1 every cycle; exc_req is ignored; branch/stall rules 2-5 still apply for hold_pc/hold_if.
  - The flush counter decrements each cycle; at 0, state<=RUN on the next edge.
  - With EXC_FLUSH_CYCLES=2, exactly 2 cycles of EXC_FLUSH follow the except cycle.
- md counter:
  - md_start=1 loads MULT_CYCLES or DIV_CYCLES per md_is_div.
  - Otherwise it decrements when nonzero.
  - md_busy = (counter != 0).
  - md_start while busy reloads the counter (restart semantics).
  - md_start in the same cycle as exc_req is dropped: the counter is not loaded.
- stall_cycles increments by 1 on every edge where hold_pc=1 and wraps from 0xFFFF_FFFF to 0.
- Reset asserted mid-stall or mid-flush returns to the reset state immediately; no output glitch is required to be held.

Test Plan:
- Reset release, imem_ready=1, no requests -> all control outputs 0, md_busy=0, stall_cycles=0.
- ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> hold_pc=hold_if=flush_id=1 that cycle only; stall_cycles=1. Repeat with ex_rt=0 -> no stall.
- md_start=1, md_is_div=1, then id_reads_hilo=1 held -> md_busy for 33 cycles, hold_pc=1 for those 33 cycles, released on the 34th; stall_cycles=33.
- exc_req=1, exc_pc=0x0040_0010, with ex_br_taken=1 the same cycle -> except=1, br=0; epc=0x0040_0010 next cycle; flush_id=1 for 3 consecutive cycles total; a second exc_req during flush is ignored.
- ex_br_taken=1, ex_br_target=0x0040_0100, with imem_ready=0 and a load-use hazard present -> br=1, pc_branch=0x0040_0100, hold_pc=0, flush_id=1.
- md_start during an active stall with DIV_CYCLES remaining 10, md_is_div=0 -> counter reloads to 5; assert rst=0 mid-count -> md_busy=0 and state=RUN immediately.

Source files
------------

// File: rtl/fetch_hazard_ctrl.sv
// IF-stage sequencing controller: arbitrates exception redirects, taken
// branches and stall sources (HI/LO busy, load-use, imem wait), drives the
// IF stage hold/redirect controls and the ID/EX bubble, and keeps the
// mult/div busy counter, exception-flush sequencer and stall counter.
module fetch_hazard_ctrl #(
    parameter int MULT_CYCLES      = 5,
    parameter int DIV_CYCLES       = 33,
    parameter int EXC_FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_reads_hilo,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        imem_ready,
    output logic        hold_pc,
    output logic        hold_if,
    output logic        flush_id,
    output logic        br,
    output logic        except,
    output logic [31:0] pc_branch,
    output logic [31:0] epc,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);
    localparam int FL_W   = $clog2(EXC_FLUSH_CYCLES) + 1;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        EXC_FLUSH = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [FL_W-1:0] fl_cnt;
    logic [FL_W-1:0] fl_cnt_next;
    logic [MD_W-1:0] md_cnt;
    logic            exc_take;
    logic            load_use;
    logic            hilo_haz;

    assign md_busy  = (md_cnt != '0);
    assign hilo_haz = md_busy && id_reads_hilo;
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    // An exception is only accepted from RUN; during the flush window it is ignored.
    assign exc_take = rst && (state == RUN) && exc_req;

    // Next-state and prioritised control outputs; everything held at 0 while in reset.
    always_comb begin
        hold_pc     = 1'b0;
        hold_if     = 1'b0;
        flush_id    = 1'b0;
        br          = 1'b0;
        except      = 1'b0;
        pc_branch   = 32'd0;
        state_next  = state;
        fl_cnt_next = fl_cnt;
        if (rst) begin
            if (exc_take) begin
                except      = 1'b1;
                flush_id    = 1'b1;
                state_next  = EXC_FLUSH;
                fl_cnt_next = FL_W'(EXC_FLUSH_CYCLES - 1);
            end else begin
                if (ex_br_taken) begin
                    br        = 1'b1;
                    pc_branch = ex_br_target;
                    flush_id  = 1'b1;
                end else if (hilo_haz || load_use || !imem_ready) begin
                    hold_pc  = 1'b1;
                    hold_if  = 1'b1;
                    flush_id = 1'b1;
                end
                if (state == EXC_FLUSH) begin
                    flush_id = 1'b1;
                    if (fl_cnt == '0) begin
                        state_next = RUN;
                    end else begin
                        fl_cnt_next = fl_cnt - FL_W'(1);
                    end
                end
            end
        end
    end

    // Sequencer state and flush countdown register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            fl_cnt <= '0;
        end else begin
            state  <= state_next;
            fl_cnt <= fl_cnt_next;
        end
    end

    // Capture the faulting PC when an exception redirect is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc <= 32'd0;
        end else if (exc_take) begin
            epc <= exc_pc;
        end
    end

    // HI/LO busy countdown; a new start reloads, a start alongside an exception is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_cnt <= '0;
        end else if (md_start && !exc_take) begin
            md_cnt <= md_is_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

    // Count every cycle the PC is frozen; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
        end else if (hold_pc) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scoreboard bench for fetch_hazard_ctrl: the stimulus process queues the
// expected outputs for each cycle, the monitor pops and compares on negedge.
module tb_fetch_hazard_ctrl;

    logic        clk = 1'b1;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_reads_hilo, ex_memread, ex_br_taken;
    logic [31:0] ex_br_target, exc_pc;
    logic        exc_req, md_start, md_is_div, imem_ready;
    logic        hold_pc, hold_if, flush_id, br, except, md_busy;
    logic [31:0] pc_branch, epc, stall_cycles;

    fetch_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_reads_hilo(id_reads_hilo), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .exc_req(exc_req),
        .exc_pc(exc_pc), .md_start(md_start), .md_is_div(md_is_div),
        .imem_ready(imem_ready), .hold_pc(hold_pc), .hold_if(hold_if),
        .flush_id(flush_id), .br(br), .except(except), .pc_branch(pc_branch),
        .epc(epc), .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  ctl;   // {hold_pc, hold_if, flush_id, br, except}
        logic        mdb;
        logic [31:0] pcb;
        logic [31:0] epc;
        logic [31:0] stall;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_epc   = 32'd0;
    logic [31:0] exp_stall = 32'd0;

    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_STALL = 5'b11100;
    localparam logic [4:0] C_BR    = 5'b00110;
    localparam logic [4:0] C_EXC   = 5'b00101;
    localparam logic [4:0] C_FLUSH = 5'b00100;

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            n_tests = n_tests + 1;
            if ({hold_pc, hold_if, flush_id, br, except} !== cur.ctl || md_busy !== cur.mdb ||
                pc_branch !== cur.pcb || epc !== cur.epc || stall_cycles !== cur.stall) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got ctl=%b md_busy=%b pc_branch=%h epc=%h stall=%0d, want ctl=%b md_busy=%b pc_branch=%h epc=%h stall=%0d",
                         cur.name, {hold_pc, hold_if, flush_id, br, except}, md_busy, pc_branch,
                         epc, stall_cycles, cur.ctl, cur.mdb, cur.pcb, cur.epc, cur.stall);
            end
        end
    end

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_reads_hilo = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0; ex_br_taken = 1'b0; ex_br_target = 32'd0;
        exc_req = 1'b0; exc_pc = 32'd0; md_start = 1'b0; md_is_div = 1'b0;
        imem_ready = 1'b1;
    endtask

    // Queue this cycle's expectation, then advance one clock.
    task automatic chk(input string nm, input logic [4:0] ctl, input logic mdb,
                       input logic [31:0] pcb);
        exp_t e;
        e.name = nm; e.ctl = ctl; e.mdb = mdb; e.pcb = pcb;
        e.epc = exp_epc; e.stall = exp_stall;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (ctl[4]) exp_stall = exp_stall + 32'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held: requests present but every control output must stay 0.
        rst = 1'b0;
        idle();
        imem_ready = 1'b0; exc_req = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h1111_0000;
        chk("reset_gate0", C_IDLE, 1'b0, 32'd0);
        chk("reset_gate1", C_IDLE, 1'b0, 32'd0);
        rst = 1'b1;
        idle();
        chk("run_idle0", C_IDLE, 1'b0, 32'd0);
        chk("run_idle1", C_IDLE, 1'b0, 32'd0);

        // Load-use on rs, on rt, and the non-hazard variants.
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        chk("lu_rs", C_STALL, 1'b0, 32'd0);
        idle();
        chk("lu_rs_after", C_IDLE, 1'b0, 32'd0);
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        chk("lu_r0", C_IDLE, 1'b0, 32'd0);
        ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
        chk("lu_rt", C_STALL, 1'b0, 32'd0);
        id_uses_rt = 1'b0;
        chk("lu_rt_unused", C_IDLE, 1'b0, 32'd0);
        idle();
        imem_ready = 1'b0;
        chk("imem_wait", C_STALL, 1'b0, 32'd0);
        idle();

        // Divide: 33 busy cycles with an MFHI waiting, released on the 34th.
        md_start = 1'b1; md_is_div = 1'b1;
        chk("div_start", C_IDLE, 1'b0, 32'd0);
        idle();
        id_reads_hilo = 1'b1;
        for (int i = 0; i < 33; i++) chk("div_hilo_stall", C_STALL, 1'b1, 32'd0);
        chk("div_hilo_release", C_IDLE, 1'b0, 32'd0);
        idle();

        // Exception beats a same-cycle branch and drops a same-cycle md_start.
        exc_req = 1'b1; exc_pc = 32'h0040_0010; ex_br_taken = 1'b1;
        ex_br_target = 32'h0000_1234; md_start = 1'b1; md_is_div = 1'b1;
        chk("exc_take", C_EXC, 1'b0, 32'd0);
        exp_epc = 32'h0040_0010;
        idle();
        exc_req = 1'b1; exc_pc = 32'h0000_DEAD;
        chk("exc_flush1_ignore", C_FLUSH, 1'b0, 32'd0);
        idle();
        imem_ready = 1'b0;
        chk("exc_flush2_stall", C_STALL, 1'b0, 32'd0);
        idle();
        chk("exc_back_to_run", C_IDLE, 1'b0, 32'd0);

        // Branch overrides imem wait and load-use.
        ex_br_taken = 1'b1; ex_br_target = 32'h0040_0100; imem_ready = 1'b0;
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        chk("br_override", C_BR, 1'b0, 32'h0040_0100);
        idle();

        // Multiply issued mid-stall with 10 divide cycles left reloads to 5.
        md_start = 1'b1; md_is_div = 1'b1;
        chk("div2_start", C_IDLE, 1'b0, 32'd0);
        idle();
        imem_ready = 1'b0;
        for (int i = 0; i < 23; i++) chk("div2_stall", C_STALL, 1'b1, 32'd0);
        md_start = 1'b1; md_is_div = 1'b0;
        chk("mul_reload", C_STALL, 1'b1, 32'd0);
        idle();
        for (int i = 0; i < 5; i++) chk("mul_busy", C_IDLE, 1'b1, 32'd0);
        chk("mul_done", C_IDLE, 1'b0, 32'd0);

        // Reset asserted mid-count and mid-flush clears everything at once.
        md_start = 1'b1; md_is_div = 1'b0;
        chk("mul2_start", C_IDLE, 1'b0, 32'd0);
        idle();
        chk("mul2_busy", C_IDLE, 1'b1, 32'd0);
        exc_req = 1'b1; exc_pc = 32'h0040_0020;
        chk("exc2_take", C_EXC, 1'b1, 32'd0);
        exp_epc = 32'h0040_0020;
        idle();
        imem_ready = 1'b0;
        rst = 1'b0;
        exp_epc = 32'd0; exp_stall = 32'd0;
        chk("reset_mid", C_IDLE, 1'b0, 32'd0);
        rst = 1'b1;
        idle();
        chk("reset_rel_run", C_IDLE, 1'b0, 32'd0);
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        chk("post_reset_lu", C_STALL, 1'b0, 32'd0);
        idle();
        chk("post_reset_count", C_IDLE, 1'b0, 32'd0);

        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
